// File: rtl/ddr2pe_loader.sv
`default_nettype none
// ============================================================================
//  Module      : ddr2pe_loader
//  Description : Loads PE-group buffers from two DDR streams.
//                ddr1 (data)  : one beat -> one data-buffer word, groups are
//                               filled lowest-enabled first, dbuf_num words
//                               each, addresses wrap modulo BUF_DEPTH.
//                ddr2 (index) : one beat -> IDX_PER_BEAT index words written
//                               one per cycle (lane 0 first), broadcast to all
//                               enabled groups.
//                Runs once per start pulse; done pulses after the last write.
//  Ports       : clk, rst (async, active high)
//                start, cfg_grp_mask, cfg_idx_num, cfg_dbuf_num, cfg_dbuf_base
//                done, busy
//                ddr1_data/valid/ready, ddr2_data/valid/ready
//                idx_wr_addr/data/en, dbuf_wr_addr/data/en (all registered)
//  Revision    : 1.0  initial release
// ============================================================================
module ddr2pe_loader #(
    parameter int GRP_NUM   = 4,
    parameter int DDR_W     = 256,
    parameter int WORD_W    = 256,
    parameter int IDX_W     = 16,
    parameter int BUF_DEPTH = 256,
    parameter int IDX_DEPTH = 256
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic [GRP_NUM-1:0]           cfg_grp_mask,
    input  logic [$clog2(IDX_DEPTH):0]   cfg_idx_num,
    input  logic [$clog2(BUF_DEPTH):0]   cfg_dbuf_num,
    input  logic [$clog2(BUF_DEPTH)-1:0] cfg_dbuf_base,
    output logic                         done,
    output logic                         busy,
    input  logic [DDR_W-1:0]             ddr1_data,
    input  logic                         ddr1_valid,
    output logic                         ddr1_ready,
    input  logic [DDR_W-1:0]             ddr2_data,
    input  logic                         ddr2_valid,
    output logic                         ddr2_ready,
    output logic [$clog2(IDX_DEPTH)-1:0] idx_wr_addr,
    output logic [2*IDX_W-1:0]           idx_wr_data,
    output logic [GRP_NUM-1:0]           idx_wr_en,
    output logic [$clog2(BUF_DEPTH)-1:0] dbuf_wr_addr,
    output logic [WORD_W-1:0]            dbuf_wr_data,
    output logic [GRP_NUM-1:0]           dbuf_wr_en
);

    localparam int IA           = $clog2(IDX_DEPTH);
    localparam int BA           = $clog2(BUF_DEPTH);
    localparam int IW2          = 2 * IDX_W;
    localparam int IDX_PER_BEAT = DDR_W / IW2;
    localparam int LANE_W       = (IDX_PER_BEAT > 1) ? $clog2(IDX_PER_BEAT) : 1;
    localparam int LAST_LANE    = IDX_PER_BEAT - 1;

    localparam logic [BA:0]        C_BUF_DEPTH = BUF_DEPTH[BA:0];
    localparam logic [BA:0]        C_W_ONE     = {{BA{1'b0}}, 1'b1};
    localparam logic [IA:0]        C_I_ONE     = {{IA{1'b0}}, 1'b1};
    localparam logic [LANE_W-1:0]  C_L_ONE     = {{(LANE_W-1){1'b0}}, 1'b1};
    localparam logic [GRP_NUM-1:0] C_G_ONE     = {{(GRP_NUM-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    // Latched configuration
    logic [GRP_NUM-1:0] r_mask;
    logic [IA:0]        r_idx_num;
    logic [BA:0]        r_dbuf_num;
    logic [BA-1:0]      r_base;

    // Data channel: groups still waiting for words, and words written to the
    // current group
    logic [GRP_NUM-1:0] r_pend;
    logic [BA:0]        r_wcnt;

    // Index channel: unpack register (shifted down one lane per write)
    logic [DDR_W-1:0]   r_ubuf;
    logic               r_ufull;
    logic [LANE_W-1:0]  r_lane;
    logic [IA:0]        r_icnt;

    logic [GRP_NUM-1:0] w_cur_oh;
    logic               w_d_fin;
    logic               w_i_fin;
    logic               w_d_xfer;
    logic               w_i_xfer;
    logic [BA:0]        w_addr_sum;

    // Lowest set bit of the pending mask is the group currently being filled
    assign w_cur_oh   = r_pend & (~r_pend + C_G_ONE);
    assign w_d_fin    = (r_pend == '0);
    assign w_i_fin    = (r_icnt == r_idx_num) && !r_ufull;

    assign ddr1_ready = (r_state == S_LOAD) && !w_d_fin;
    assign ddr2_ready = (r_state == S_LOAD) && !r_ufull && (r_icnt != r_idx_num);
    assign w_d_xfer   = ddr1_valid && ddr1_ready;
    assign w_i_xfer   = ddr2_valid && ddr2_ready;

    assign busy = (r_state == S_LOAD);
    assign done = (r_state == S_DONE);

    // base < BUF_DEPTH and word count < BUF_DEPTH, so one subtraction wraps
    assign w_addr_sum = {1'b0, r_base} + r_wcnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Both channel-finished flags only become true once the final write has
    // been registered, so DONE follows the last write by exactly one cycle.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (start) w_state_nxt = S_LOAD;
            S_LOAD:  if (w_d_fin && w_i_fin) w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mask       <= '0;
            r_idx_num    <= '0;
            r_dbuf_num   <= '0;
            r_base       <= '0;
            r_pend       <= '0;
            r_wcnt       <= '0;
            r_ubuf       <= '0;
            r_ufull      <= 1'b0;
            r_lane       <= '0;
            r_icnt       <= '0;
            idx_wr_addr  <= '0;
            idx_wr_data  <= '0;
            idx_wr_en    <= '0;
            dbuf_wr_addr <= '0;
            dbuf_wr_data <= '0;
            dbuf_wr_en   <= '0;
        end else begin
            dbuf_wr_en <= '0;
            idx_wr_en  <= '0;

            if (r_state == S_IDLE && start) begin
                r_mask     <= cfg_grp_mask;
                r_dbuf_num <= cfg_dbuf_num;
                r_base     <= cfg_dbuf_base;
                // A zero count or empty mask leaves that channel finished
                r_pend     <= (cfg_dbuf_num != '0) ? cfg_grp_mask : '0;
                r_idx_num  <= (cfg_grp_mask != '0) ? cfg_idx_num : '0;
                r_wcnt     <= '0;
                r_icnt     <= '0;
                r_ufull    <= 1'b0;
                r_lane     <= '0;
            end

            if (w_d_xfer) begin
                dbuf_wr_en   <= w_cur_oh;
                dbuf_wr_addr <= BA'((w_addr_sum >= C_BUF_DEPTH) ?
                                    (w_addr_sum - C_BUF_DEPTH) : w_addr_sum);
                dbuf_wr_data <= ddr1_data;
                if (r_wcnt + C_W_ONE == r_dbuf_num) begin
                    r_pend <= r_pend & ~w_cur_oh;
                    r_wcnt <= '0;
                end else begin
                    r_wcnt <= r_wcnt + C_W_ONE;
                end
            end

            if (w_i_xfer) begin
                r_ubuf  <= ddr2_data;
                r_ufull <= 1'b1;
                r_lane  <= '0;
            end else if (r_ufull) begin
                idx_wr_en   <= r_mask;
                idx_wr_addr <= IA'(r_icnt);
                idx_wr_data <= r_ubuf[IW2-1:0];
                r_ubuf      <= r_ubuf >> IW2;
                r_icnt      <= r_icnt + C_I_ONE;
                r_lane      <= r_lane + C_L_ONE;
                // Empty after the last lane, or early once idx_num is reached
                if (r_lane == LAST_LANE[LANE_W-1:0] || r_icnt + C_I_ONE == r_idx_num) begin
                    r_ufull <= 1'b0;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ddr2pe_loader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ddr2pe_loader
//  Description : Self-checking bench for ddr2pe_loader. Random beats are fed
//                with random valid gaps; expected writes are derived from the
//                configuration and the beat lists.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_ddr2pe_loader;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [3:0]   cfg_grp_mask;
    logic [8:0]   cfg_idx_num;
    logic [8:0]   cfg_dbuf_num;
    logic [7:0]   cfg_dbuf_base;
    logic         done;
    logic         busy;
    logic [255:0] ddr1_data;
    logic         ddr1_valid;
    logic         ddr1_ready;
    logic [255:0] ddr2_data;
    logic         ddr2_valid;
    logic         ddr2_ready;
    logic [7:0]   idx_wr_addr;
    logic [31:0]  idx_wr_data;
    logic [3:0]   idx_wr_en;
    logic [7:0]   dbuf_wr_addr;
    logic [255:0] dbuf_wr_data;
    logic [3:0]   dbuf_wr_en;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    ddr2pe_loader dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .cfg_grp_mask  (cfg_grp_mask),
        .cfg_idx_num   (cfg_idx_num),
        .cfg_dbuf_num  (cfg_dbuf_num),
        .cfg_dbuf_base (cfg_dbuf_base),
        .done          (done),
        .busy          (busy),
        .ddr1_data     (ddr1_data),
        .ddr1_valid    (ddr1_valid),
        .ddr1_ready    (ddr1_ready),
        .ddr2_data     (ddr2_data),
        .ddr2_valid    (ddr2_valid),
        .ddr2_ready    (ddr2_ready),
        .idx_wr_addr   (idx_wr_addr),
        .idx_wr_data   (idx_wr_data),
        .idx_wr_en     (idx_wr_en),
        .dbuf_wr_addr  (dbuf_wr_addr),
        .dbuf_wr_data  (dbuf_wr_data),
        .dbuf_wr_en    (dbuf_wr_en)
    );

    function automatic logic [255:0] rand256();
        logic [255:0] r;
        for (int k = 0; k < 8; k++) r[32*k +: 32] = $urandom;
        return r;
    endfunction

    // One complete load: start, stream beats, compare every write, check done.
    task automatic run_case(input logic [3:0] mask, input int dnum, input int base,
                            input int inum, input int gap, input bit mid_start,
                            input string name);
        logic [255:0] d_beats[$];
        logic [255:0] i_beats[$];
        logic [3:0]   ed_en[$];
        logic [7:0]   ed_addr[$];
        logic [255:0] ed_data[$];
        logic [7:0]   ei_addr[$];
        logic [31:0]  ei_data[$];
        logic [255:0] b;
        int nd, ni, k, d_ptr, i_ptr, n0, last_wr, done_n, exp_done;
        bit busy_bad, rdy_bad;

        nd = (dnum == 0) ? 0 : $countones(mask) * dnum;
        ni = (mask == 4'b0) ? 0 : (inum + 7) / 8;
        for (int j = 0; j < nd; j++) d_beats.push_back(rand256());
        for (int j = 0; j < ni; j++) i_beats.push_back(rand256());

        // Reference: groups ascending, dnum words each, wrapped addresses
        k = 0;
        for (int g = 0; g < 4; g++)
            if (mask[g])
                for (int j = 0; j < dnum; j++) begin
                    ed_en.push_back(4'(1 << g));
                    ed_addr.push_back(8'((base + j) % 256));
                    ed_data.push_back(d_beats[k]);
                    k++;
                end
        // Reference: word w is lane w%8 of beat w/8, address w
        if (mask != 4'b0)
            for (int w = 0; w < inum; w++) begin
                b = i_beats[w / 8];
                ei_addr.push_back(8'(w));
                ei_data.push_back(b[32*(w % 8) +: 32]);
            end

        d_ptr = 0; i_ptr = 0; last_wr = -1; done_n = -1;
        busy_bad = 1'b0; rdy_bad = 1'b0;

        @(posedge clk); #1;
        cfg_grp_mask  = mask;
        cfg_dbuf_num  = 9'(dnum);
        cfg_dbuf_base = 8'(base);
        cfg_idx_num   = 9'(inum);
        start         = 1'b1;
        ddr1_valid    = 1'b0;
        ddr2_valid    = 1'b0;
        n0            = cyc;

        for (int it = 0; it < 3000; it++) begin
            @(negedge clk);
            if (dbuf_wr_en != 4'b0) begin
                n_cmp++;
                last_wr = cyc;
                if (ed_en.size() == 0) begin
                    n_err++;
                    $display("FAIL %s dbuf extra write: got en=%b addr=%0d, want none", name, dbuf_wr_en, dbuf_wr_addr);
                end else begin
                    if (dbuf_wr_en !== ed_en[0] || dbuf_wr_addr !== ed_addr[0] || dbuf_wr_data !== ed_data[0]) begin
                        n_err++;
                        $display("FAIL %s dbuf write: got en=%b addr=%0d data=%h, want en=%b addr=%0d data=%h",
                                 name, dbuf_wr_en, dbuf_wr_addr, dbuf_wr_data, ed_en[0], ed_addr[0], ed_data[0]);
                    end
                    void'(ed_en.pop_front()); void'(ed_addr.pop_front()); void'(ed_data.pop_front());
                end
            end
            if (idx_wr_en != 4'b0) begin
                n_cmp++;
                last_wr = cyc;
                if (ei_addr.size() == 0) begin
                    n_err++;
                    $display("FAIL %s idx extra write: got en=%b addr=%0d, want none", name, idx_wr_en, idx_wr_addr);
                end else begin
                    if (idx_wr_en !== mask || idx_wr_addr !== ei_addr[0] || idx_wr_data !== ei_data[0]) begin
                        n_err++;
                        $display("FAIL %s idx write: got en=%b addr=%0d data=%h, want en=%b addr=%0d data=%h",
                                 name, idx_wr_en, idx_wr_addr, idx_wr_data, mask, ei_addr[0], ei_data[0]);
                    end
                    void'(ei_addr.pop_front()); void'(ei_data.pop_front());
                end
            end
            if (cyc > n0 && done !== 1'b1 && busy !== 1'b1) busy_bad = 1'b1;
            if ((ddr1_ready && d_ptr >= nd) || (ddr2_ready && i_ptr >= ni)) rdy_bad = 1'b1;
            if (done === 1'b1) begin
                done_n = cyc;
                break;
            end
            if (ddr1_valid && ddr1_ready) d_ptr++;
            if (ddr2_valid && ddr2_ready) i_ptr++;

            @(posedge clk); #1;
            if (mid_start && it == 4) begin
                start         = 1'b1;
                cfg_grp_mask  = 4'($urandom);
                cfg_dbuf_num  = 9'($urandom_range(1, 20));
                cfg_dbuf_base = 8'($urandom);
                cfg_idx_num   = 9'($urandom_range(1, 200));
            end else begin
                start = 1'b0;
            end
            ddr1_valid = (d_ptr < nd) && ($urandom_range(0, 99) >= gap);
            ddr1_data  = ddr1_valid ? d_beats[d_ptr] : rand256();
            ddr2_valid = (i_ptr < ni) && ($urandom_range(0, 99) >= gap);
            ddr2_data  = ddr2_valid ? i_beats[i_ptr] : rand256();
        end

        n_cmp++;
        if (done_n < 0) begin
            n_err++;
            $display("FAIL %s done timeout: got no done, want done within budget", name);
        end else begin
            exp_done = (last_wr < 0) ? n0 + 2 : last_wr + 1;
            if (done_n != exp_done) begin
                n_err++;
                $display("FAIL %s done timing: got cycle %0d, want %0d", name, done_n, exp_done);
            end
        end
        n_cmp++;
        if (ed_en.size() != 0 || ei_addr.size() != 0) begin
            n_err++;
            $display("FAIL %s missing writes: got %0d dbuf/%0d idx outstanding, want 0/0", name, ed_en.size(), ei_addr.size());
        end
        n_cmp++;
        if (rdy_bad || busy_bad) begin
            n_err++;
            $display("FAIL %s ready/busy: got ready_overrun=%0b busy_drop=%0b, want 0/0", name, rdy_bad, busy_bad);
        end

        @(posedge clk); #1;
        start = 1'b0; ddr1_valid = 1'b0; ddr2_valid = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (done !== 1'b0 || busy !== 1'b0 || dbuf_wr_en !== 4'b0 || idx_wr_en !== 4'b0) begin
            n_err++;
            $display("FAIL %s after done: got done=%b busy=%b den=%b ien=%b, want 0 0 0000 0000",
                     name, done, busy, dbuf_wr_en, idx_wr_en);
        end
    endtask

    task automatic check_all_zero(input string name);
        n_cmp++;
        if ({done, busy, ddr1_ready, ddr2_ready, idx_wr_en, dbuf_wr_en} !== 12'b0) begin
            n_err++;
            $display("FAIL %s control: got done=%b busy=%b r1=%b r2=%b ien=%b den=%b, want all 0",
                     name, done, busy, ddr1_ready, ddr2_ready, idx_wr_en, dbuf_wr_en);
        end
        n_cmp++;
        if (idx_wr_addr !== 8'b0 || dbuf_wr_addr !== 8'b0 || idx_wr_data !== 32'b0 || dbuf_wr_data !== 256'b0) begin
            n_err++;
            $display("FAIL %s addr/data: got iaddr=%0d daddr=%0d idata=%h, want 0", name, idx_wr_addr, dbuf_wr_addr, idx_wr_data);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; ddr1_valid = 1'b0; ddr2_valid = 1'b0;
        cfg_grp_mask = 4'b0; cfg_idx_num = 9'b0; cfg_dbuf_num = 9'b0; cfg_dbuf_base = 8'b0;
        ddr1_data = '0; ddr2_data = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_all_zero("reset");
        #2 rst = 1'b0;
    endtask

    task automatic test_fill_all();
        run_case(4'b1111, 3, 250, 0, 0, 1'b0, "fill_all");
    endtask

    task automatic test_wrap_mask();
        run_case(4'b0101, 2, 255, 0, 0, 1'b0, "wrap_mask");
    endtask

    task automatic test_index_unpack();
        run_case(4'b0011, 0, 0, 10, 0, 1'b0, "index_unpack");
    endtask

    task automatic test_concurrent();
        run_case(4'b1111, 4, $urandom_range(0, 255), 16, 30, 1'b1, "concurrent");
    endtask

    task automatic test_all_zero();
        run_case(4'b0000, 0, 0, 0, 0, 1'b0, "all_zero");
        run_case(4'b0000, 5, 17, 40, 0, 1'b0, "mask_zero");
    endtask

    task automatic test_random();
        for (int r = 0; r < 6; r++)
            run_case(4'($urandom), $urandom_range(0, 6), $urandom_range(0, 255),
                     $urandom_range(0, 60), $urandom_range(0, 50), 1'b0, "random");
        run_case(4'b1000, 1, 3, 256, 10, 1'b0, "idx_full_depth");
    endtask

    task automatic test_reset_midload();
        @(posedge clk); #1;
        cfg_grp_mask = 4'b1111; cfg_dbuf_num = 9'd4; cfg_dbuf_base = 8'd9; cfg_idx_num = 9'd16;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < 6; i++) begin
            ddr1_valid = 1'b1; ddr1_data = rand256();
            ddr2_valid = 1'b1; ddr2_data = rand256();
            @(posedge clk); #1;
        end
        @(negedge clk);
        #2 rst = 1'b1;
        #1 check_all_zero("reset_midload");
        ddr1_valid = 1'b0; ddr2_valid = 1'b0;
        @(posedge clk); @(posedge clk); #3 rst = 1'b0;
        @(negedge clk);
        check_all_zero("after_reset");
        run_case(4'b1111, 3, 250, 0, 0, 1'b0, "rerun_fill_all");
    endtask

    initial begin
        test_reset();
        test_fill_all();
        test_wrap_mask();
        test_index_unpack();
        test_concurrent();
        test_all_zero();
        test_random();
        test_reset_midload();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
